// File: rtl/lut_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lut_cfg_pkg
// Purpose  : Shared FSM encoding and beat-counter sizing for the LUT config writer.
// Revision : 1.0
// ============================================================================
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_WRITE  = 2'd3
    } cfg_state_t;

    // A single-beat load still needs a one-bit counter so the port has width.
    function automatic int beat_cnt_width(input int mem_size, input int config_width);
        int beats;
        beats = mem_size / config_width;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_cfg_shifter.sv
`default_nettype none
// ============================================================================
// Module   : lut_cfg_shifter
// Purpose  : Config beat shift register and beat counter with a final-beat flag.
// Revision : 1.0
// ============================================================================
module lut_cfg_shifter
    import lut_cfg_pkg::*;
#(
    parameter int MEM_SIZE     = 16,
    parameter int CONFIG_WIDTH = 4
) (
    input  logic                    cclk,
    input  logic                    rst,
    input  logic                    shift_en,
    input  logic                    clear,
    input  logic [CONFIG_WIDTH-1:0] data,
    output logic [MEM_SIZE-1:0]     next_word,
    output logic                    last,
    output logic                    done
);

    localparam int                 c_BEATS = MEM_SIZE / CONFIG_WIDTH;
    localparam int                 c_CNT_W = beat_cnt_width(MEM_SIZE, CONFIG_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_BEATS - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Only the beats already received are stored; the word in flight is
    // those beats with the current beat appended in the LSBs.
    generate
        if (MEM_SIZE == CONFIG_WIDTH) begin : g_single_beat
            assign next_word = data;
        end else begin : g_multi_beat
            logic [MEM_SIZE-CONFIG_WIDTH-1:0] r_shreg;

            assign next_word = {r_shreg, data};

            always_ff @(posedge cclk or posedge rst) begin
                if (rst) begin
                    r_shreg <= '0;
                end else if (shift_en) begin
                    r_shreg <= next_word[MEM_SIZE-CONFIG_WIDTH-1:0];
                end
            end
        end
    endgenerate

    assign last = (r_cnt == c_LAST);
    assign done = shift_en && last;

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear || done) begin
            r_cnt <= '0;
        end else if (shift_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lut_m_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module   : lut_m_cfg_writer
// Purpose  : Streams config beats into a LUT word and issues single-bit writes.
// Revision : 1.0
// ============================================================================
module lut_m_cfg_writer
    import lut_cfg_pkg::*;
#(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2**INPUTS,
    parameter int CONFIG_WIDTH = 4
) (
    input  logic                    cclk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CONFIG_WIDTH-1:0] cfg_data,
    input  logic                    cfg_abort,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [INPUTS-1:0]       wr_addr,
    input  logic                    wr_data,
    output logic [MEM_SIZE-1:0]     config_out,
    output logic                    cen,
    output logic [INPUTS-1:0]       waddr,
    output logic                    data_out,
    output logic                    write_en,
    output logic                    busy
);

    cfg_state_t          r_state;
    cfg_state_t          w_state_nxt;
    logic                w_beat;
    logic                w_clear;
    logic                w_last;
    logic                w_done;
    logic [MEM_SIZE-1:0] w_next_word;

    lut_cfg_shifter #(
        .MEM_SIZE     (MEM_SIZE),
        .CONFIG_WIDTH (CONFIG_WIDTH)
    ) u_shifter (
        .cclk      (cclk),
        .rst       (rst),
        .shift_en  (w_beat),
        .clear     (w_clear),
        .data      (cfg_data),
        .next_word (w_next_word),
        .last      (w_last),
        .done      (w_done)
    );

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cfg_ready   = 1'b0;
        wr_ready    = 1'b0;
        w_beat      = 1'b0;
        w_clear     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // A pending write takes the slot, so the beat is refused.
                wr_ready  = 1'b1;
                cfg_ready = !wr_valid;
                if (wr_valid) begin
                    w_state_nxt = ST_WRITE;
                end else if (cfg_valid) begin
                    w_beat      = 1'b1;
                    w_state_nxt = w_last ? ST_COMMIT : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cfg_ready = 1'b1;
                if (cfg_abort) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (cfg_valid) begin
                    w_beat = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            ST_WRITE:  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // The assembled word is captured on the same edge that enters COMMIT.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            config_out <= '0;
        end else if (w_done) begin
            config_out <= w_next_word;
        end
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            waddr    <= '0;
            data_out <= 1'b0;
        end else if ((r_state == ST_IDLE) && wr_valid) begin
            waddr    <= wr_addr;
            data_out <= wr_data;
        end
    end

    assign cen      = (r_state == ST_COMMIT);
    assign write_en = (r_state == ST_WRITE);
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lut_m_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_m_cfg_writer
// Purpose  : Directed vector table, reset corner cases and scoreboarded traffic.
// Revision : 1.0
// ============================================================================
module tb_lut_m_cfg_writer;

    logic        cclk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_data;
    logic        cfg_abort;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic        wr_data;
    logic [15:0] config_out;
    logic        cen;
    logic [3:0]  waddr;
    logic        data_out;
    logic        write_en;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    lut_m_cfg_writer #(
        .INPUTS       (4),
        .MEM_SIZE     (16),
        .CONFIG_WIDTH (4)
    ) dut (
        .cclk       (cclk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_abort  (cfg_abort),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .config_out (config_out),
        .cen        (cen),
        .waddr      (waddr),
        .data_out   (data_out),
        .write_en   (write_en),
        .busy       (busy)
    );

    always #5 cclk = ~cclk;

    typedef struct {
        logic        cv;
        logic [3:0]  cd;
        logic        ab;
        logic        wv;
        logic [3:0]  wa;
        logic        wd;
        logic        e_cfg_ready;
        logic        e_wr_ready;
        logic        e_cen;
        logic        e_we;
        logic        e_busy;
        logic [15:0] e_cfg;
        logic [3:0]  e_waddr;
        logic        e_do;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic cv, input logic [3:0] cd, input logic ab,
                                input logic wv, input logic [3:0] wa, input logic wd,
                                input logic ecr, input logic ewr, input logic ecen,
                                input logic ewe, input logic ebusy, input logic [15:0] ecfg,
                                input logic [3:0] ewa, input logic edo);
        vec_t v;
        v.cv = cv; v.cd = cd; v.ab = ab; v.wv = wv; v.wa = wa; v.wd = wd;
        v.e_cfg_ready = ecr; v.e_wr_ready = ewr; v.e_cen = ecen; v.e_we = ewe;
        v.e_busy = ebusy; v.e_cfg = ecfg; v.e_waddr = ewa; v.e_do = edo;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [3:0] cd, input logic ab,
                         input logic wv, input logic [3:0] wa, input logic wd);
        cfg_valid = cv; cfg_data = cd; cfg_abort = ab;
        wr_valid  = wv; wr_addr  = wa; wr_data   = wd;
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " config_out"}, 32'(config_out), 32'h0);
        check({tag, " cen"},        32'(cen),        32'h0);
        check({tag, " write_en"},   32'(write_en),   32'h0);
        check({tag, " waddr"},      32'(waddr),      32'h0);
        check({tag, " data_out"},   32'(data_out),   32'h0);
        check({tag, " busy"},       32'(busy),       32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [15:0] lut_exp;
        logic [15:0] lut_dut;
        logic [15:0] beat_acc;
        logic [15:0] exp_cfg;
        int          nbeats;
        int          exp_cen_cnt;
        int          got_cen_cnt;
        int          exp_we_cnt;
        int          got_we_cnt;
        logic [3:0]  seq_a[4];
        logic [3:0]  seq_b[4];

        rst = 1'b1;
        drive(0, 4'h0, 0, 0, 4'h0, 0);
        repeat (2) @(posedge cclk);
        #1;
        check_all_zero("reset");
        check("reset cfg_ready", 32'(cfg_ready), 32'h1);
        check("reset wr_ready",  32'(wr_ready),  32'h1);
        rst = 1'b0;

        //           cv cd    ab wv wa    wd cr wr cen we bsy cfg       wa    do
        vq.push_back(mk(1, 4'hA, 0, 0, 4'h0, 0, 1, 1, 0, 0, 1, 16'h0000, 4'h0, 0));
        vq.push_back(mk(1, 4'hB, 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 16'h0000, 4'h0, 0));
        vq.push_back(mk(1, 4'hC, 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 16'h0000, 4'h0, 0));
        vq.push_back(mk(1, 4'hD, 0, 0, 4'h0, 0, 1, 0, 1, 0, 1, 16'hABCD, 4'h0, 0));
        vq.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 16'hABCD, 4'h0, 0));
        // single write
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h5, 1, 0, 1, 0, 1, 1, 16'hABCD, 4'h5, 1));
        vq.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 16'hABCD, 4'h5, 1));
        // write and beat together: write first, beat retried
        vq.push_back(mk(1, 4'h5, 0, 1, 4'hA, 0, 0, 1, 0, 1, 1, 16'hABCD, 4'hA, 0));
        vq.push_back(mk(1, 4'h5, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 16'hABCD, 4'hA, 0));
        vq.push_back(mk(1, 4'h5, 0, 0, 4'h0, 0, 1, 1, 0, 0, 1, 16'hABCD, 4'hA, 0));
        vq.push_back(mk(1, 4'h6, 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 16'hABCD, 4'hA, 0));
        vq.push_back(mk(1, 4'h7, 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 16'hABCD, 4'hA, 0));
        vq.push_back(mk(1, 4'h8, 0, 0, 4'h0, 0, 1, 0, 1, 0, 1, 16'h5678, 4'hA, 0));
        vq.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 16'h5678, 4'hA, 0));
        // two beats then abort (abort beats a same-cycle beat)
        vq.push_back(mk(1, 4'hF, 0, 0, 4'h0, 0, 1, 1, 0, 0, 1, 16'h5678, 4'hA, 0));
        vq.push_back(mk(1, 4'hE, 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 16'h5678, 4'hA, 0));
        vq.push_back(mk(1, 4'h7, 1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 16'h5678, 4'hA, 0));
        vq.push_back(mk(0, 4'h0, 1, 0, 4'h0, 0, 1, 1, 0, 0, 0, 16'h5678, 4'hA, 0));
        // fresh load; a write offered mid-load is not taken
        vq.push_back(mk(1, 4'h1, 0, 0, 4'h0, 0, 1, 1, 0, 0, 1, 16'h5678, 4'hA, 0));
        vq.push_back(mk(1, 4'h2, 0, 1, 4'h3, 1, 1, 0, 0, 0, 1, 16'h5678, 4'hA, 0));
        vq.push_back(mk(1, 4'h3, 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 16'h5678, 4'hA, 0));
        vq.push_back(mk(1, 4'h4, 0, 0, 4'h0, 0, 1, 0, 1, 0, 1, 16'h1234, 4'hA, 0));
        vq.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 16'h1234, 4'hA, 0));
        // back-to-back writes: at most one per two cycles
        vq.push_back(mk(0, 4'h0, 0, 1, 4'hF, 1, 0, 1, 0, 1, 1, 16'h1234, 4'hF, 1));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h3, 0, 0, 0, 0, 0, 0, 16'h1234, 4'hF, 1));
        vq.push_back(mk(0, 4'h0, 0, 1, 4'h3, 0, 0, 1, 0, 1, 1, 16'h1234, 4'h3, 0));
        vq.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 16'h1234, 4'h3, 0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].cv, vq[i].cd, vq[i].ab, vq[i].wv, vq[i].wa, vq[i].wd);
            #1;
            check($sformatf("v%0d cfg_ready", i), 32'(cfg_ready), 32'(vq[i].e_cfg_ready));
            check($sformatf("v%0d wr_ready", i),  32'(wr_ready),  32'(vq[i].e_wr_ready));
            tick();
            check($sformatf("v%0d cen", i),        32'(cen),        32'(vq[i].e_cen));
            check($sformatf("v%0d write_en", i),   32'(write_en),   32'(vq[i].e_we));
            check($sformatf("v%0d busy", i),       32'(busy),       32'(vq[i].e_busy));
            check($sformatf("v%0d config_out", i), 32'(config_out), 32'(vq[i].e_cfg));
            check($sformatf("v%0d waddr", i),      32'(waddr),      32'(vq[i].e_waddr));
            check($sformatf("v%0d data_out", i),   32'(data_out),   32'(vq[i].e_do));
        end
        drive(0, 4'h0, 0, 0, 4'h0, 0);

        // reset after three beats of a load
        seq_a = '{4'h9, 4'h8, 4'h7, 4'h6};
        for (int i = 0; i < 3; i++) begin
            drive(1, seq_a[i], 0, 0, 4'h0, 0);
            tick();
        end
        drive(0, 4'h0, 0, 0, 4'h0, 0);
        check("midload busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midload rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post-rst cen", 32'(cen), 32'h0);
            check("post-rst busy", 32'(busy), 32'h0);
        end
        seq_b = '{4'hC, 4'h0, 4'hD, 4'hE};
        for (int i = 0; i < 4; i++) begin
            drive(1, seq_b[i], 0, 0, 4'h0, 0);
            tick();
            check($sformatf("reload beat%0d cen", i), 32'(cen), (i == 3) ? 32'h1 : 32'h0);
        end
        drive(0, 4'h0, 0, 0, 4'h0, 0);
        check("reload config_out", 32'(config_out), 32'hC0DE);
        tick();

        // reset during a write cycle
        drive(0, 4'h0, 0, 1, 4'h9, 1);
        tick();
        drive(0, 4'h0, 0, 0, 4'h0, 0);
        check("midwrite write_en", 32'(write_en), 32'h1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midwrite rst");
        tick();
        rst = 1'b0;
        tick();
        check("post-rst write_en", 32'(write_en), 32'h0);
        check("post-rst idle busy", 32'(busy), 32'h0);

        // random interleaved traffic, scoreboarded by handshakes
        lut_exp = 16'h0; lut_dut = 16'h0; beat_acc = 16'h0; exp_cfg = 16'h0;
        nbeats = 0; exp_cen_cnt = 0; got_cen_cnt = 0; exp_we_cnt = 0; got_we_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc < 390) begin
                drive(($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), 0,
                      ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            end else begin
                drive(0, 4'h0, 0, 0, 4'h0, 0);
            end
            #1;
            if (cfg_valid && cfg_ready) begin
                beat_acc = {beat_acc[11:0], cfg_data};
                nbeats++;
                if (nbeats == 4) begin
                    lut_exp = beat_acc;
                    exp_cfg = beat_acc;
                    exp_cen_cnt++;
                    nbeats = 0;
                end
            end
            if (wr_valid && wr_ready) begin
                lut_exp[wr_addr] = wr_data;
                exp_we_cnt++;
            end
            tick();
            if (cen && write_en) begin
                check("rand cen/write_en overlap", 32'({cen, write_en}), 32'h0);
            end
            if (cen) begin
                got_cen_cnt++;
                lut_dut = config_out;
                check("rand config_out", 32'(config_out), 32'(exp_cfg));
            end
            if (write_en) begin
                got_we_cnt++;
                lut_dut[waddr] = data_out;
            end
        end
        check("rand lut contents", 32'(lut_dut), 32'(lut_exp));
        check("rand cen count", 32'(got_cen_cnt), 32'(exp_cen_cnt));
        check("rand write count", 32'(got_we_cnt), 32'(exp_we_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
